// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle of the control-path signals exchanged between the multi-cycle main
//   controller and the datapath / memory port.
//
//   Parameter:
//     RETIRE_W    width of the retired-instruction counter
//   Inputs to the controller (driven by the datapath side):
//     opcode      IR[31:26]
//     zero        ALU zero flag
//     mem_ready   memory finishes the current access this cycle
//   Outputs of the controller:
//     mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
//     alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done,
//     illegal_op, state (debug), retired
//   Modports:
//     master      controller view
//     slave       datapath view
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int RETIRE_W = 16
);
  logic [5:0]          opcode;
  logic                zero;
  logic                mem_ready;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                ir_write;
  logic                pc_en;
  logic [1:0]          pc_source;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                instr_done;
  logic                illegal_op;
  logic [3:0]          state;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           instr_done, illegal_op, state, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           instr_done, illegal_op, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multi-cycle MIPS-subset datapath. Sequences each
//   instruction through FETCH / DECODE / execute / memory / write-back over a
//   single shared memory port stalled by mem_ready, and counts retired
//   instructions.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   multicycle_control_if.master (opcode/zero/mem_ready in, all
//           control strobes, selects, debug state and retired count out)
//
//   Configuration macro:
//     MC_CTRL_JUMP_EN  when defined, opcode 0x02 executes through the JUMP
//                      state; otherwise 0x02 is treated as illegal.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
`ifdef MC_CTRL_JUMP_EN
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
`else
    S_BRANCH   = 4'd8
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  state_e              state_q;
  state_e              state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic [RETIRE_W-1:0] retired_d;

  logic       mem_read_s;
  logic       mem_write_s;
  logic       i_or_d_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] pc_source_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       instr_done_s;
  logic       illegal_op_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore/Mealy control decode.
  always_comb begin
    state_d         = state_q;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    i_or_d_s        = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = 2'b00;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    instr_done_s    = 1'b0;
    illegal_op_s    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        // IR load and PC+4 commit only on the cycle the fetch completes.
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALUOut <= PC + (imm << 2): branch target computed ahead of time.
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_op_s = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_LW) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        // A store retires on the cycle memory accepts it.
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d      = S_MEM_WR;
        end
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        instr_done_s    = 1'b1;
        state_d         = S_FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b10;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
`endif
      default: begin
        // Unused codes recover to FETCH with every output inactive.
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter next value; wraps naturally.
  always_comb begin
    if (instr_done_s) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  // Outputs are gated by rst so that FETCH's mem_read does not show while
  // reset is held, and an aborted instruction emits no strobe.
  assign bus.mem_read   = mem_read_s   & ~rst;
  assign bus.mem_write  = mem_write_s  & ~rst;
  assign bus.i_or_d     = i_or_d_s     & ~rst;
  assign bus.ir_write   = ir_write_s   & ~rst;
  assign bus.pc_en      = (pc_write_s | (pc_write_cond_s & bus.zero)) & ~rst;
  assign bus.pc_source  = rst ? 2'b00 : pc_source_s;
  assign bus.alu_src_a  = alu_src_a_s  & ~rst;
  assign bus.alu_src_b  = rst ? 2'b00 : alu_src_b_s;
  assign bus.alu_op     = rst ? 2'b00 : alu_op_s;
  assign bus.reg_dst    = reg_dst_s    & ~rst;
  assign bus.mem_to_reg = mem_to_reg_s & ~rst;
  assign bus.reg_write  = reg_write_s  & ~rst;
  assign bus.instr_done = instr_done_s & ~rst;
  assign bus.illegal_op = illegal_op_s & ~rst;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;
  logic [15:0] exp_ret = 16'd0;

  always #5 clk = ~clk;

  multicycle_control_if #(.RETIRE_W(16)) bus ();
  multicycle_control_if #(.RETIRE_W(3))  bus_w ();

  multicycle_control #(.RETIRE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy fed identical stimulus, used to observe wrap-around.
  multicycle_control #(.RETIRE_W(3)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  task automatic set_in(input logic [5:0] op, input logic z, input logic rdy);
    bus.opcode      = op;
    bus.zero        = z;
    bus.mem_ready   = rdy;
    bus_w.opcode    = op;
    bus_w.zero      = z;
    bus_w.mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(6'h00, 1'b0, 1'b1);
    tick();
    tick();
    total++; if (bus.state !== 4'd0) $display("FAIL rst_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.mem_read !== 1'b0) $display("FAIL rst_mem_read got %b want 0", bus.mem_read); else passed++;
    total++; if (bus.ir_write !== 1'b0) $display("FAIL rst_ir_write got %b want 0", bus.ir_write); else passed++;
    total++; if (bus.pc_en !== 1'b0) $display("FAIL rst_pc_en got %b want 0", bus.pc_en); else passed++;
    total++; if (bus.alu_src_b !== 2'b00) $display("FAIL rst_alu_src_b got %b want 00", bus.alu_src_b); else passed++;
    total++; if (bus.retired !== 16'd0) $display("FAIL rst_retired got %0d want 0", bus.retired); else passed++;
    rst = 1'b0;
    exp_ret = 16'd0;
    #1;
    total++; if (bus.mem_read !== 1'b1) $display("FAIL first_fetch_mem_read got %b want 1", bus.mem_read); else passed++;
    total++; if (bus.i_or_d !== 1'b0) $display("FAIL first_fetch_i_or_d got %b want 0", bus.i_or_d); else passed++;
  endtask

  task automatic test_rtype();
    set_in(6'h00, 1'b0, 1'b0);
    #1;
    total++; if (bus.state !== 4'd0) $display("FAIL r_fetch_wait_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.mem_read !== 1'b1) $display("FAIL r_fetch_wait_mem_read got %b want 1", bus.mem_read); else passed++;
    total++; if (bus.ir_write !== 1'b0) $display("FAIL r_fetch_wait_ir_write got %b want 0", bus.ir_write); else passed++;
    total++; if (bus.pc_en !== 1'b0) $display("FAIL r_fetch_wait_pc_en got %b want 0", bus.pc_en); else passed++;
    tick();
    set_in(6'h00, 1'b0, 1'b1);
    #1;
    total++; if (bus.state !== 4'd0) $display("FAIL r_fetch_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.ir_write !== 1'b1) $display("FAIL r_fetch_ir_write got %b want 1", bus.ir_write); else passed++;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL r_fetch_pc_en got %b want 1", bus.pc_en); else passed++;
    total++; if (bus.alu_src_b !== 2'b01) $display("FAIL r_fetch_alu_src_b got %b want 01", bus.alu_src_b); else passed++;
    tick();
    total++; if (bus.state !== 4'd1) $display("FAIL r_decode_state got %0d want 1", bus.state); else passed++;
    total++; if (bus.alu_src_b !== 2'b11) $display("FAIL r_decode_alu_src_b got %b want 11", bus.alu_src_b); else passed++;
    total++; if (bus.mem_read !== 1'b0) $display("FAIL r_decode_mem_read got %b want 0", bus.mem_read); else passed++;
    tick();
    total++; if (bus.state !== 4'd6) $display("FAIL r_exec_state got %0d want 6", bus.state); else passed++;
    total++; if (bus.alu_op !== 2'b10) $display("FAIL r_exec_alu_op got %b want 10", bus.alu_op); else passed++;
    total++; if (bus.alu_src_a !== 1'b1) $display("FAIL r_exec_alu_src_a got %b want 1", bus.alu_src_a); else passed++;
    total++; if (bus.alu_src_b !== 2'b00) $display("FAIL r_exec_alu_src_b got %b want 00", bus.alu_src_b); else passed++;
    tick();
    total++; if (bus.state !== 4'd7) $display("FAIL r_wb_state got %0d want 7", bus.state); else passed++;
    total++; if (bus.reg_write !== 1'b1) $display("FAIL r_wb_reg_write got %b want 1", bus.reg_write); else passed++;
    total++; if (bus.reg_dst !== 1'b1) $display("FAIL r_wb_reg_dst got %b want 1", bus.reg_dst); else passed++;
    total++; if (bus.mem_to_reg !== 1'b0) $display("FAIL r_wb_mem_to_reg got %b want 0", bus.mem_to_reg); else passed++;
    total++; if (bus.instr_done !== 1'b1) $display("FAIL r_wb_instr_done got %b want 1", bus.instr_done); else passed++;
    tick();
    exp_ret = exp_ret + 16'd1;
    total++; if (bus.state !== 4'd0) $display("FAIL r_end_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL r_retired got %0d want %0d", bus.retired, exp_ret); else passed++;
  endtask

  task automatic test_lw_wait();
    set_in(6'h23, 1'b0, 1'b1);
    #1;
    total++; if (bus.state !== 4'd0) $display("FAIL lw_fetch_state got %0d want 0", bus.state); else passed++;
    tick();
    total++; if (bus.state !== 4'd1) $display("FAIL lw_decode_state got %0d want 1", bus.state); else passed++;
    tick();
    total++; if (bus.state !== 4'd2) $display("FAIL lw_addr_state got %0d want 2", bus.state); else passed++;
    total++; if (bus.alu_src_b !== 2'b10) $display("FAIL lw_addr_alu_src_b got %b want 10", bus.alu_src_b); else passed++;
    total++; if (bus.alu_src_a !== 1'b1) $display("FAIL lw_addr_alu_src_a got %b want 1", bus.alu_src_a); else passed++;
    tick();
    for (int w = 0; w < 3; w++) begin
      set_in(6'h23, 1'b0, (w == 2) ? 1'b1 : 1'b0);
      #1;
      total++; if (bus.state !== 4'd3) $display("FAIL lw_rd_state[%0d] got %0d want 3", w, bus.state); else passed++;
      total++; if (bus.mem_read !== 1'b1) $display("FAIL lw_rd_mem_read[%0d] got %b want 1", w, bus.mem_read); else passed++;
      total++; if (bus.i_or_d !== 1'b1) $display("FAIL lw_rd_i_or_d[%0d] got %b want 1", w, bus.i_or_d); else passed++;
      tick();
    end
    total++; if (bus.state !== 4'd4) $display("FAIL lw_wb_state got %0d want 4", bus.state); else passed++;
    total++; if (bus.mem_to_reg !== 1'b1) $display("FAIL lw_wb_mem_to_reg got %b want 1", bus.mem_to_reg); else passed++;
    total++; if (bus.reg_write !== 1'b1) $display("FAIL lw_wb_reg_write got %b want 1", bus.reg_write); else passed++;
    total++; if (bus.reg_dst !== 1'b0) $display("FAIL lw_wb_reg_dst got %b want 0", bus.reg_dst); else passed++;
    total++; if (bus.instr_done !== 1'b1) $display("FAIL lw_wb_instr_done got %b want 1", bus.instr_done); else passed++;
    tick();
    exp_ret = exp_ret + 16'd1;
    total++; if (bus.state !== 4'd0) $display("FAIL lw_end_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL lw_retired got %0d want %0d", bus.retired, exp_ret); else passed++;
  endtask

  task automatic test_sw_wait();
    set_in(6'h2B, 1'b0, 1'b1);
    tick();
    tick();
    total++; if (bus.state !== 4'd2) $display("FAIL sw_addr_state got %0d want 2", bus.state); else passed++;
    tick();
    set_in(6'h2B, 1'b0, 1'b0);
    #1;
    total++; if (bus.state !== 4'd5) $display("FAIL sw_wr_wait_state got %0d want 5", bus.state); else passed++;
    total++; if (bus.mem_write !== 1'b1) $display("FAIL sw_wr_wait_mem_write got %b want 1", bus.mem_write); else passed++;
    total++; if (bus.i_or_d !== 1'b1) $display("FAIL sw_wr_wait_i_or_d got %b want 1", bus.i_or_d); else passed++;
    total++; if (bus.instr_done !== 1'b0) $display("FAIL sw_wr_wait_instr_done got %b want 0", bus.instr_done); else passed++;
    tick();
    set_in(6'h2B, 1'b0, 1'b1);
    #1;
    total++; if (bus.mem_write !== 1'b1) $display("FAIL sw_wr_mem_write got %b want 1", bus.mem_write); else passed++;
    total++; if (bus.instr_done !== 1'b1) $display("FAIL sw_wr_instr_done got %b want 1", bus.instr_done); else passed++;
    total++; if (bus.reg_write !== 1'b0) $display("FAIL sw_wr_reg_write got %b want 0", bus.reg_write); else passed++;
    tick();
    exp_ret = exp_ret + 16'd1;
    total++; if (bus.state !== 4'd0) $display("FAIL sw_end_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL sw_retired got %0d want %0d", bus.retired, exp_ret); else passed++;
  endtask

  task automatic test_beq(input logic z);
    set_in(6'h04, z, 1'b1);
    tick();
    tick();
    total++; if (bus.state !== 4'd8) $display("FAIL beq%0d_state got %0d want 8", z, bus.state); else passed++;
    total++; if (bus.pc_en !== z) $display("FAIL beq%0d_pc_en got %b want %b", z, bus.pc_en, z); else passed++;
    total++; if (bus.pc_source !== 2'b01) $display("FAIL beq%0d_pc_source got %b want 01", z, bus.pc_source); else passed++;
    total++; if (bus.alu_op !== 2'b01) $display("FAIL beq%0d_alu_op got %b want 01", z, bus.alu_op); else passed++;
    total++; if (bus.instr_done !== 1'b1) $display("FAIL beq%0d_instr_done got %b want 1", z, bus.instr_done); else passed++;
    // pc_en must follow zero within the same cycle.
    set_in(6'h04, ~z, 1'b1);
    #1;
    total++; if (bus.pc_en !== ~z) $display("FAIL beq%0d_pc_en_follow got %b want %b", z, bus.pc_en, ~z); else passed++;
    set_in(6'h04, z, 1'b1);
    tick();
    exp_ret = exp_ret + 16'd1;
    total++; if (bus.state !== 4'd0) $display("FAIL beq%0d_end_state got %0d want 0", z, bus.state); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL beq%0d_retired got %0d want %0d", z, bus.retired, exp_ret); else passed++;
  endtask

  task automatic test_illegal(input logic [5:0] op);
    set_in(op, 1'b0, 1'b1);
    tick();
    total++; if (bus.state !== 4'd1) $display("FAIL ill_%h_state got %0d want 1", op, bus.state); else passed++;
    total++; if (bus.illegal_op !== 1'b1) $display("FAIL ill_%h_pulse got %b want 1", op, bus.illegal_op); else passed++;
    total++; if (bus.instr_done !== 1'b0) $display("FAIL ill_%h_instr_done got %b want 0", op, bus.instr_done); else passed++;
    tick();
    total++; if (bus.state !== 4'd0) $display("FAIL ill_%h_end_state got %0d want 0", op, bus.state); else passed++;
    total++; if (bus.illegal_op !== 1'b0) $display("FAIL ill_%h_pulse_end got %b want 0", op, bus.illegal_op); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL ill_%h_retired got %0d want %0d", op, bus.retired, exp_ret); else passed++;
  endtask

  task automatic test_jump();
`ifdef MC_CTRL_JUMP_EN
    set_in(6'h02, 1'b0, 1'b1);
    tick();
    total++; if (bus.illegal_op !== 1'b0) $display("FAIL j_decode_illegal got %b want 0", bus.illegal_op); else passed++;
    tick();
    total++; if (bus.state !== 4'd9) $display("FAIL j_state got %0d want 9", bus.state); else passed++;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL j_pc_en got %b want 1", bus.pc_en); else passed++;
    total++; if (bus.pc_source !== 2'b10) $display("FAIL j_pc_source got %b want 10", bus.pc_source); else passed++;
    total++; if (bus.instr_done !== 1'b1) $display("FAIL j_instr_done got %b want 1", bus.instr_done); else passed++;
    tick();
    exp_ret = exp_ret + 16'd1;
    total++; if (bus.state !== 4'd0) $display("FAIL j_end_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL j_retired got %0d want %0d", bus.retired, exp_ret); else passed++;
`else
    test_illegal(6'h02);
`endif
  endtask

  task automatic test_reset_mid_store();
    set_in(6'h2B, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    set_in(6'h2B, 1'b0, 1'b0);
    tick();
    total++; if (bus.state !== 4'd5) $display("FAIL mid_pre_state got %0d want 5", bus.state); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.state !== 4'd0) $display("FAIL mid_rst_state got %0d want 0", bus.state); else passed++;
    total++; if (bus.mem_write !== 1'b0) $display("FAIL mid_rst_mem_write got %b want 0", bus.mem_write); else passed++;
    total++; if (bus.retired !== 16'd0) $display("FAIL mid_rst_retired got %0d want 0", bus.retired); else passed++;
    total++; if (bus.instr_done !== 1'b0) $display("FAIL mid_rst_instr_done got %b want 0", bus.instr_done); else passed++;
    tick();
    exp_ret = 16'd0;
    set_in(6'h00, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    total++; if (bus.mem_read !== 1'b1) $display("FAIL mid_restart_mem_read got %b want 1", bus.mem_read); else passed++;
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 7; n++) begin
      set_in(6'h04, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      exp_ret = exp_ret + 16'd1;
    end
    total++; if (bus_w.retired !== 3'b111) $display("FAIL wrap_all_ones got %0d want 7", bus_w.retired); else passed++;
    set_in(6'h04, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    exp_ret = exp_ret + 16'd1;
    total++; if (bus_w.retired !== 3'b000) $display("FAIL wrap_zero got %0d want 0", bus_w.retired); else passed++;
    total++; if (bus.retired !== exp_ret) $display("FAIL wrap_wide got %0d want %0d", bus.retired, exp_ret); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal(6'h3F);
    test_jump();
    test_reset_mid_store();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the MIPS-subset datapath. It sequences each instruction through fetch, decode, execute, memory and write-back using a shared memory port that is stalled by a ready handshake. It drives the PC enable, IR load, register-bank write, mux selects and the 2-bit ALUOp consumed by `alu_control`. It also tracks retired instructions.

## Interface
- `RETIRE_W`, 16: width of the retired-instruction counter.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: instruction bits [31:26] from the IR, valid from DECODE onward.
- `zero` input 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` input 1: memory completes the current access in this cycle.
- `mem_read`, `mem_write` output 1 each: memory strobes.
- `i_or_d` output 1: memory address select (0 = PC, 1 = ALUOut).
- `ir_write` output 1: load the IR.
- `pc_en` output 1: PC load, `pc_write | (pc_write_cond & zero)`.
- `pc_source` output 2: next-PC select (00 = ALU, 01 = ALUOut, 10 = jump target).
- `alu_src_a` output 1: ALU A select (0 = PC, 1 = rs).
- `alu_src_b` output 2: ALU B select (00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2).
- `alu_op` output 2: ALUOp (00 = add, 01 = sub, 10 = funct).
- `reg_dst` output 1: write-register select (0 = rt, 1 = rd).
- `mem_to_reg` output 1: write-data select (0 = ALUOut, 1 = MDR).
- `reg_write` output 1: register-bank write.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `illegal_op` output 1: one-cycle pulse in DECODE on an unsupported opcode.
- `state` output 4: current state code, for debug.
- `retired` output RETIRE_W: count of retired instructions.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9.
  - Codes 10–15 are unreachable and return to FETCH on the next edge.
- Outputs are combinational from `state`, `mem_ready`, `zero` and `opcode`. Any output not listed for a state is 0.
- FETCH:
  - `mem_read = 1`, `i_or_d = 0`, `alu_src_a = 0`, `alu_src_b = 01`, `alu_op = 00`, `pc_source = 00`.
  - `ir_write` and `pc_write` are asserted only when `mem_ready = 1`.
  - Next state is DECODE if `mem_ready`, otherwise stay in FETCH.
- DECODE:
  - `alu_src_a = 0`, `alu_src_b = 11`, `alu_op = 00` (branch target precompute).
  - Next state by opcode: 0x00 → EXEC; 0x23 or 0x2B → MEM_ADDR; 0x04 → BRANCH; 0x02 → JUMP (see Configuration).
  - Any other opcode → FETCH with `illegal_op = 1`.
- MEM_ADDR:
  - `alu_src_a = 1`, `alu_src_b = 10`, `alu_op = 00`.
  - Next state is MEM_RD if opcode = 0x23, otherwise MEM_WR.
- MEM_RD:
  - `mem_read = 1`, `i_or_d = 1`.
  - Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB:
  - `reg_write = 1`, `mem_to_reg = 1`, `reg_dst = 0`, `instr_done = 1`.
  - Next state is FETCH.
- MEM_WR:
  - `mem_write = 1`, `i_or_d = 1`.
  - Hold until `mem_ready`. On the ready cycle, `instr_done = 1` and go to FETCH.
- EXEC:
  - `alu_src_a = 1`, `alu_src_b = 00`, `alu_op = 10`.
  - Next state is R_WB.
- R_WB:
  - `reg_write = 1`, `reg_dst = 1`, `mem_to_reg = 0`, `instr_done = 1`.
  - Next state is FETCH.
- BRANCH:
  - `alu_src_a = 1`, `alu_src_b = 00`, `alu_op = 01`, `pc_write_cond = 1`, `pc_source = 01`, `instr_done = 1`.
  - Next state is FETCH.
- JUMP:
  - `pc_write = 1`, `pc_source = 10`, `instr_done = 1`.
  - Next state is FETCH.
- Retired counter:
  - `retired` increments on every clock edge where `instr_done = 1`.
  - It wraps from all-ones to 0 with no saturation.
  - Illegal opcodes are not counted.

## Timing
- Reset:
  - While `rst` is high, `state` = FETCH and `retired` = 0.
  - All strobes (`mem_read`, `mem_write`, `ir_write`, `pc_en`, `reg_write`, `instr_done`, `illegal_op`) are forced to 0 and all selects to 0.
  - Asserting reset mid-instruction aborts it immediately: no write-back, no count.
- First FETCH after reset deassertion: memory is accessed in the first cycle, i.e. `mem_read = 1` from the first cycle with `rst` low.
- Cycle counts with zero wait states (`mem_ready` held high):
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each low `mem_ready` cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Strobes stay asserted and addresses stay stable while waiting.
- `pc_en` in BRANCH follows `zero` combinationally in that same cycle.

## Configuration
- `MC_CTRL_JUMP_EN`:
  - Defined: opcode 0x02 goes DECODE → JUMP → FETCH.
  - Undefined: the JUMP state is not compiled, and opcode 0x02 is illegal (`illegal_op` pulse, return to FETCH, not counted).

## Test plan
- Reset, then `mem_ready = 1` with opcode 0x00 → states 0,1,6,7 in order; `reg_write = 1` with `reg_dst = 1` in state 7; `retired = 1`.
- lw (0x23) with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total; `mem_to_reg = 1` in MEM_WB; `mem_read` held high across the wait.
- beq (0x04) with `zero = 1`, then again with `zero = 0` → `pc_en = 1` and `pc_source = 01` in BRANCH for the first; `pc_en = 0` for the second; both counted.
- Opcode 0x3F → `illegal_op` pulse in DECODE, back to FETCH, `retired` unchanged; repeat with 0x02 under both macro settings.
- Preload `retired = 0xFFFF` via 65535 sw instructions (or force), retire one more → `retired = 0x0000`.
- `rst` pulsed during MEM_WR while `mem_ready = 0` → state = FETCH, `mem_write = 0` immediately, `retired = 0`.
